// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU constants and types used by the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle: imem request/response, redirect from decode, decode handoff.
interface instr_fetch_queue_if;
    import instr_fetch_queue_pkg::*;

    logic            imem_req_valid_o;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_req_ready_i;
    logic            imem_rsp_valid_i;
    logic [XLEN-1:0] imem_rsp_data_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            id_valid_o;
    logic            id_ready_i;
    logic [XLEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, id_valid_o, id_instr_o, id_pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, id_valid_o, id_instr_o, id_pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_i, redirect_pc_i, id_ready_i
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Registered {pc, instr} FIFO with synchronous clear; no read-through bypass.
module fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  fq_entry_t                    wdata_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output fq_entry_t                    rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy next-state; clear overrides any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order responses,
// redirect flush with drop accounting for responses still in flight.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_fetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   out_cnt_q, out_cnt_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count;
    fq_entry_t       head;
    fq_entry_t       push_entry;
    logic            req_valid, accept, rsp_ok, drop_now, keep, pop, id_valid;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = word_align(bus.redirect_pc_i);

    // Request credit: never more in flight than the queue can still absorb.
    assign req_valid = rst_i && !bus.redirect_i
                    && (int'(out_cnt_q) < MAX_OUT)
                    && (int'(count) + int'(out_cnt_q) < DEPTH);
    assign accept    = req_valid && bus.imem_req_ready_i;
    assign rsp_ok    = bus.imem_rsp_valid_i && (out_cnt_q != '0);
    assign drop_now  = rsp_ok && (drop_cnt_q != '0);
    assign keep      = rsp_ok && !drop_now && !bus.redirect_i;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && bus.id_ready_i;

    assign push_entry = '{pc: rsp_pc_q, instr: bus.imem_rsp_data_i};

    // Next-state for fetch PC, response PC and in-flight accounting.
    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        out_cnt_d = out_cnt_q + OW'(accept) - OW'(rsp_ok);
        drop_cnt_d = drop_cnt_q - OW'(drop_now);
        if (bus.redirect_i) begin
            pc_d     = redirect_tgt;
            rsp_pc_d = redirect_tgt;
            // Nothing is issued in a redirect cycle, so every request still in
            // flight after this edge belongs to the old stream.
            drop_cnt_d = out_cnt_q - OW'(rsp_ok);
        end else begin
            if (accept) pc_d     = pc_q + 32'd4;
            if (keep)   rsp_pc_d = rsp_pc_q + 32'd4;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (keep),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .clear_i (bus.redirect_i),
        .rdata_o (head),
        .count_o (count)
    );

    assign bus.imem_req_valid_o = req_valid;
    assign bus.imem_req_addr_o  = pc_q;
    assign bus.id_valid_o       = id_valid;
    assign bus.id_instr_o       = id_valid ? head.instr : NOP_INSTR;
    assign bus.id_pc_o          = id_valid ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: imem model with in-order delayed responses and a
// program-order reference model of the delivered instruction stream.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit rsp_rand = 1'b0;
    int n_rsp    = 0;

    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    logic [31:0] acc_addr[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    logic        s_req_valid, s_id_valid, s_redirect;
    logic [31:0] s_req_addr, s_id_pc, s_id_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: sample at negedge, update imem model, drive next response after posedge.
    task automatic tick();
        @(negedge clk);
        s_req_valid = bus.imem_req_valid_o;
        s_req_addr  = bus.imem_req_addr_o;
        s_id_valid  = bus.id_valid_o;
        s_id_pc     = bus.id_pc_o;
        s_id_instr  = bus.id_instr_o;
        s_redirect  = bus.redirect_i;
        if (rst_i) begin
            if (bus.imem_rsp_valid_i) begin
                void'(pend_addr.pop_front());
                void'(pend_cyc.pop_front());
                n_rsp++;
            end
            if (s_req_valid && bus.imem_req_ready_i) begin
                pend_addr.push_back(s_req_addr);
                pend_cyc.push_back(cyc);
                acc_addr.push_back(s_req_addr);
            end
            if (s_id_valid && bus.id_ready_i) begin
                got_pc.push_back(s_id_pc);
                got_instr.push_back(s_id_instr);
            end
        end else begin
            pend_addr.delete();
            pend_cyc.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_i && pend_addr.size() > 0 && cyc >= pend_cyc[0] + lat &&
            (!rsp_rand || $urandom_range(0, 1) == 1)) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_word(pend_addr[0]);
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.id_ready_i       = 1'b0;
        pend_addr.delete();
        pend_cyc.delete();
        repeat (3) tick();
        rst_i = 1'b1;
        cyc = 0;
        n_rsp = 0;
        acc_addr.delete();
        got_pc.delete();
        got_instr.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (s_req_valid !== 1'b0 || s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids req=%b id=%b required 0 0", s_req_valid, s_id_valid);
        end
        n_checks++;
        if (s_id_instr !== NOP_INSTR || s_id_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_id instr=%h pc=%h required %h 0", s_id_instr, s_id_pc, NOP_INSTR);
        end
        bus.imem_req_ready_i = 1'b1;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req valid=%b addr=%h required 1 %h", s_req_valid, s_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (i < 2) begin
                if (s_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early cycle %0d id_valid=%b required 0", i, s_id_valid);
                end
            end else if (s_id_valid !== 1'b1 || s_id_pc !== 32'(4 * (i - 2)) ||
                         s_id_instr !== mem_word(32'(4 * (i - 2)))) begin
                n_fail++;
                $display("FAIL stream_seq cycle %0d valid=%b pc=%h instr=%h required 1 %h %h",
                         i, s_id_valid, s_id_pc, s_id_instr, 4 * (i - 2), mem_word(32'(4 * (i - 2))));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat = 1; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (s_id_valid !== 1'b1 || s_req_valid !== 1'b0 || pend_addr.size() != 0 || acc_addr.size() != 4) begin
            n_fail++;
            $display("FAIL stall_state id_valid=%b req_valid=%b outstanding=%0d fetched=%0d required 1 0 0 4",
                     s_id_valid, s_req_valid, pend_addr.size(), acc_addr.size());
        end
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (s_id_valid !== 1'b1 || s_id_pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stall_drain pop %0d valid=%b pc=%h required 1 %h", i, s_id_valid, s_id_pc, 4 * i);
            end
        end
        for (int i = 0; i < 10 && acc_addr.size() < 5; i++) tick();
        n_checks++;
        if (acc_addr.size() < 5 || acc_addr[4] !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_resume fetched=%0d next_addr=%h required 16", acc_addr.size(),
                     acc_addr.size() >= 5 ? acc_addr[4] : 32'hx);
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 1'b0;
        do_reset();
        lat = 4; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (pend_addr.size() == 2 && pend_addr[0] == 32'h8 && pend_addr[1] == 32'hC);
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL drop_setup outstanding=%0d required 8 and c in flight", pend_addr.size());
        end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h100;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_req_in_redirect req_valid=%b required 0", s_req_valid);
        end
        bus.redirect_i = 1'b0;
        got_pc.delete();
        got_instr.delete();
        tick();
        n_checks++;
        if (s_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_flush id_valid=%b required 0", s_id_valid);
        end
        for (int i = 0; i < 40 && got_pc.size() == 0; i++) tick();
        n_checks++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h100 || got_instr[0] !== mem_word(32'h100)) begin
            n_fail++;
            $display("FAIL drop_first pops=%0d pc=%h instr=%h required 100 %h", got_pc.size(),
                     got_pc.size() > 0 ? got_pc[0] : 32'hx, got_pc.size() > 0 ? got_instr[0] : 32'hx,
                     mem_word(32'h100));
        end
    endtask

    task automatic test_align();
        do_reset();
        lat = 1; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b1;
        repeat (3) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h103;
        tick();
        bus.redirect_i = 1'b0;
        got_pc.delete();
        got_instr.delete();
        tick();
        n_checks++;
        if (s_req_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL align_addr addr=%h required 100", s_req_addr);
        end
        for (int i = 0; i < 20 && got_pc.size() == 0; i++) tick();
        n_checks++;
        if (got_pc.size() == 0 || got_pc[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL align_pop pc=%h required 100", got_pc.size() > 0 ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lat = 2; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b1;
        repeat (5) tick();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 32'h40;
        tick();
        bus.redirect_pc_i = 32'h80;
        tick();
        bus.redirect_i = 1'b0;
        got_pc.delete();
        got_instr.delete();
        for (int i = 0; i < 40 && got_pc.size() < 3; i++) tick();
        n_checks++;
        if (got_pc.size() < 3 || got_pc[0] !== 32'h80 || got_pc[1] !== 32'h84 || got_pc[2] !== 32'h88 ||
            got_instr[0] !== mem_word(32'h80)) begin
            n_fail++;
            $display("FAIL b2b_redirect pops=%0d first_pc=%h required 80 84 88", got_pc.size(),
                     got_pc.size() > 0 ? got_pc[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        bit ready_state = 1'b0;
        do_reset();
        lat = 1; rsp_rand = 1'b0;
        bus.imem_req_ready_i = 1'b1;
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 20 && !ready_state; i++) begin
            tick();
            ready_state = (n_rsp == 3 && pend_addr.size() == 1);
        end
        n_checks++;
        if (!ready_state || s_id_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup queued=%0d outstanding=%0d id_valid=%b required 3 1 1",
                     n_rsp, pend_addr.size(), s_id_valid);
        end
        rst_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        pend_addr.delete();
        pend_cyc.delete();
        #1;
        n_checks++;
        if (bus.imem_req_valid_o !== 1'b0 || bus.id_valid_o !== 1'b0 ||
            bus.id_instr_o !== NOP_INSTR || bus.id_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs req=%b id=%b instr=%h pc=%h required 0 0 %h 0",
                     bus.imem_req_valid_o, bus.id_valid_o, bus.id_instr_o, bus.id_pc_o, NOP_INSTR);
        end
        tick();
        tick();
        rst_i = 1'b1;
        cyc = 0; n_rsp = 0;
        acc_addr.delete(); got_pc.delete(); got_instr.delete();
        bus.id_ready_i = 1'b1;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrst_restart valid=%b addr=%h required 1 %h", s_req_valid, s_req_addr, RESET_PC);
        end
        for (int i = 0; i < 20 && got_pc.size() == 0; i++) tick();
        n_checks++;
        if (got_pc.size() == 0 || got_pc[0] !== RESET_PC || got_instr[0] !== mem_word(RESET_PC)) begin
            n_fail++;
            $display("FAIL midrst_first_pop pc=%h required %h", got_pc.size() > 0 ? got_pc[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        bit redir, prev_redir;
        int delivered = 0;
        int nfail0 = n_fail;
        do_reset();
        rsp_rand = 1'b1;
        exp_pc = RESET_PC;
        prev_redir = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) lat = $urandom_range(1, 3);
            bus.imem_req_ready_i = ($urandom_range(0, 3) != 0);
            bus.id_ready_i = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 19) == 0) || (prev_redir && $urandom_range(0, 1) == 1);
            tgt = $urandom & 32'h0000_FFFF;
            bus.redirect_i = redir;
            bus.redirect_pc_i = tgt;
            tick();
            while (got_pc.size() > 0) begin
                logic [31:0] p, w;
                p = got_pc.pop_front();
                w = got_instr.pop_front();
                delivered++;
                n_checks++;
                if (p !== exp_pc || w !== mem_word(exp_pc)) begin
                    n_fail++;
                    if (n_fail - nfail0 < 10)
                        $display("FAIL rand_stream cycle %0d pc=%h instr=%h required %h %h",
                                 c, p, w, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) exp_pc = {tgt[31:2], 2'b00};
            if (s_redirect) begin
                n_checks++;
                if (s_req_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_req_in_redirect cycle %0d req_valid=%b required 0", c, s_req_valid);
                end
            end
            if (prev_redir) begin
                n_checks++;
                if (s_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_flush cycle %0d id_valid=%b required 0", c, s_id_valid);
                end
            end
            if (!s_id_valid) begin
                n_checks++;
                if (s_id_instr !== NOP_INSTR || s_id_pc !== 32'h0) begin
                    n_fail++;
                    $display("FAIL rand_idle cycle %0d instr=%h pc=%h required %h 0", c, s_id_instr, s_id_pc, NOP_INSTR);
                end
            end
            n_checks++;
            if (pend_addr.size() > MAX_OUT || s_req_addr[1:0] !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_credit cycle %0d outstanding=%0d addr=%h required <=%0d aligned",
                         c, pend_addr.size(), s_req_addr, MAX_OUT);
            end
            prev_redir = redir;
        end
        bus.redirect_i = 1'b0;
        n_checks++;
        if (delivered < 100) begin
            n_fail++;
            $display("FAIL rand_progress delivered=%0d required >=100", delivered);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready_i = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        bus.redirect_i       = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.id_ready_i       = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_align();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
